// File: rtl/trackball_counter.sv
// -----------------------------------------------------------------------------
// trackball_counter
//
// Quadrature-style trackball front end. Two independent axes (horizontal and
// vertical) each receive an asynchronous step strobe and direction level from
// the trackball transmitter. Steps are synchronized and then collected in a
// small signed accumulator. On every game-cadence tick (ce high, not paused)
// the accumulator is added into a wrapping position counter. The CPU reads
// {v_count, h_count} through a latched port. A sticky flag reports that an
// accumulator saturated, so the CPU can tell that movement was lost.
//
// Ports
//   clk      in   system clock
//   reset_n  in   asynchronous active-low reset
//   ce       in   clock enable, game cadence; counters update only when high
//   pause    in   freezes counters; steps still accumulate
//   h_clk    in   horizontal step strobe (asynchronous)
//   h_dir    in   horizontal direction (asynchronous)
//   v_clk    in   vertical step strobe (asynchronous)
//   v_dir    in   vertical direction (asynchronous)
//   rd       in   CPU read strobe, qualified by ce
//   tb_data  out  latched {v_count, h_count}
//   sat      out  sticky accumulator-saturation flag, cleared by a read
// -----------------------------------------------------------------------------
module trackball_counter #(
  parameter int   CNT_W  = 4,
  parameter int   ACC_W  = 3,
  parameter logic DIR_UP = 1'b1
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               ce,
  input  logic               pause,
  input  logic               h_clk,
  input  logic               h_dir,
  input  logic               v_clk,
  input  logic               v_dir,
  input  logic               rd,
  output logic [2*CNT_W-1:0] tb_data,
  output logic               sat
);

  // Accumulator limits and unit steps, signed ACC_W-bit.
  localparam logic signed [ACC_W-1:0] ACC_MAX     = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN     = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic signed [ACC_W-1:0] ACC_ONE     = {{(ACC_W-1){1'b0}}, 1'b1};
  localparam logic signed [ACC_W-1:0] ACC_NEG_ONE = {ACC_W{1'b1}};
  localparam logic signed [ACC_W-1:0] ACC_ZERO    = {ACC_W{1'b0}};

  // Sign-extend an accumulator value to counter width.
  function automatic logic [CNT_W-1:0] sext_acc(input logic [ACC_W-1:0] v);
    return {{(CNT_W-ACC_W){v[ACC_W-1]}}, v};
  endfunction

  // Axis index 0 = horizontal, 1 = vertical.
  logic [1:0]       stb_in_s;
  logic [1:0]       dir_in_s;
  logic [1:0]       stb_meta_r;
  logic [1:0]       stb_sync_r;
  logic [1:0]       stb_dly_r;
  logic [1:0]       dir_meta_r;
  logic [1:0]       dir_sync_r;
  logic [1:0]       warm_cnt_r;
  logic             armed_s;
  logic [1:0]       evt_s;
  logic [1:0]       up_s;
  logic             apply_s;
  logic             rd_q_s;
  logic             sat_hit_s;

  logic signed [ACC_W-1:0] acc_r     [2];
  logic signed [ACC_W-1:0] acc_nxt_s [2];
  logic [CNT_W-1:0]        cnt_r     [2];
  logic [CNT_W-1:0]        cnt_nxt_s [2];

  assign stb_in_s = {v_clk, h_clk};
  assign dir_in_s = {v_dir, h_dir};

  // The delay flop starts at 0 after reset, so a strobe already high at
  // release would look like a rising edge; the warm-up counter masks events
  // for the first three clocks until the delay flop has caught up.
  assign armed_s = (warm_cnt_r == 2'd3);
  assign evt_s   = stb_sync_r & ~stb_dly_r & {2{armed_s}};
  assign up_s    = ~(dir_sync_r ^ {2{DIR_UP}});
  assign apply_s = ce & ~pause;
  assign rd_q_s  = rd & ce;

  // Input synchronizers, edge-detect delay flops and warm-up counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stb_meta_r <= 2'b00;
      stb_sync_r <= 2'b00;
      stb_dly_r  <= 2'b00;
      dir_meta_r <= 2'b00;
      dir_sync_r <= 2'b00;
      warm_cnt_r <= 2'd0;
    end else begin
      stb_meta_r <= stb_in_s;
      stb_sync_r <= stb_meta_r;
      stb_dly_r  <= stb_sync_r;
      dir_meta_r <= dir_in_s;
      dir_sync_r <= dir_meta_r;
      if (warm_cnt_r != 2'd3) begin
        warm_cnt_r <= warm_cnt_r + 2'd1;
      end else begin
        warm_cnt_r <= warm_cnt_r;
      end
    end
  end

  // Next-state for accumulators and counters. On an apply cycle the old
  // accumulator goes into the counter and a same-clock step seeds the new
  // accumulator, so no step is lost or counted twice.
  always_comb begin
    sat_hit_s = 1'b0;
    for (int a = 0; a < 2; a++) begin
      acc_nxt_s[a] = acc_r[a];
      cnt_nxt_s[a] = cnt_r[a];
      if (apply_s) begin
        cnt_nxt_s[a] = cnt_r[a] + sext_acc(acc_r[a]);
        if (evt_s[a]) begin
          acc_nxt_s[a] = up_s[a] ? ACC_ONE : ACC_NEG_ONE;
        end else begin
          acc_nxt_s[a] = ACC_ZERO;
        end
      end else if (evt_s[a]) begin
        if (up_s[a]) begin
          if (acc_r[a] == ACC_MAX) begin
            sat_hit_s = 1'b1;
          end else begin
            acc_nxt_s[a] = acc_r[a] + ACC_ONE;
          end
        end else begin
          if (acc_r[a] == ACC_MIN) begin
            sat_hit_s = 1'b1;
          end else begin
            acc_nxt_s[a] = acc_r[a] - ACC_ONE;
          end
        end
      end else begin
        acc_nxt_s[a] = acc_r[a];
      end
    end
  end

  // Accumulator and position counter registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int a = 0; a < 2; a++) begin
        acc_r[a] <= ACC_ZERO;
        cnt_r[a] <= {CNT_W{1'b0}};
      end
    end else begin
      for (int a = 0; a < 2; a++) begin
        acc_r[a] <= acc_nxt_s[a];
        cnt_r[a] <= cnt_nxt_s[a];
      end
    end
  end

  // CPU read latch (pre-update counter values) and sticky saturation flag;
  // a saturation in the same clock as a read wins over the clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tb_data <= {(2*CNT_W){1'b0}};
      sat     <= 1'b0;
    end else begin
      if (rd_q_s) begin
        tb_data <= {cnt_r[1], cnt_r[0]};
      end else begin
        tb_data <= tb_data;
      end
      if (sat_hit_s) begin
        sat <= 1'b1;
      end else if (rd_q_s) begin
        sat <= 1'b0;
      end else begin
        sat <= sat;
      end
    end
  end

endmodule

// File: tb/tb_trackball_counter.sv
// -----------------------------------------------------------------------------
// tb_trackball_counter
//
// Scoreboard bench for trackball_counter. The stimulus process steps a
// behavioural model (integer positions and pending deltas) once per clock and
// pushes the expected {sat, tb_data} into a queue for every qualified read.
// A separate monitor pops and compares one clock after each read edge.
// -----------------------------------------------------------------------------
module tb_trackball_counter;

  localparam int CNT_W = 4;
  localparam int ACC_W = 3;

  logic               clk;
  logic               reset_n;
  logic               ce;
  logic               pause;
  logic               h_clk;
  logic               h_dir;
  logic               v_clk;
  logic               v_dir;
  logic               rd;
  logic [2*CNT_W-1:0] tb_data;
  logic               sat;

  trackball_counter #(.CNT_W(CNT_W), .ACC_W(ACC_W), .DIR_UP(1'b1)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .ce      (ce),
    .pause   (pause),
    .h_clk   (h_clk),
    .h_dir   (h_dir),
    .v_clk   (v_clk),
    .v_dir   (v_dir),
    .rd      (rd),
    .tb_data (tb_data),
    .sat     (sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Scoreboard queue of expected {sat, tb_data}.
  logic [8:0] exp_q[$];

  // Pin values applied at the next negedge.
  logic nxt_h_clk = 1'b0, nxt_h_dir = 1'b0, nxt_v_clk = 1'b0, nxt_v_dir = 1'b0;
  logic ce_state  = 1'b0;
  logic pause_g   = 1'b0;
  bit   ce_held   = 1'b0;

  // Behavioural model: pin samples of the last three clocks, positions and
  // pending deltas as plain integers.
  int n_edge;
  bit hs1, hs2, hs3, vs1, vs2, vs3, hd1, hd2, vd1, vd2;
  int h_pos, v_pos, h_acc, v_acc;
  bit sat_m;

  function automatic void model_reset();
    n_edge = 0;
    {hs1, hs2, hs3, vs1, vs2, vs3, hd1, hd2, vd1, vd2} = '0;
    h_pos = 0; v_pos = 0; h_acc = 0; v_acc = 0;
    sat_m = 1'b0;
  endfunction

  // One axis: pending delta range is -4..+3, position wraps modulo 16.
  function automatic void model_axis(inout int pos, inout int acc,
                                     input bit evt, input bit up,
                                     input bit apply, inout bit hit);
    int d;
    d = up ? 1 : -1;
    if (apply) begin
      pos = (((pos + acc) % 16) + 16) % 16;
      acc = evt ? d : 0;
    end else if (evt) begin
      if (acc + d > 3 || acc + d < -4) hit = 1'b1;
      else acc = acc + d;
    end
  endfunction

  // A pin rising before clock n-2 produces a step at clock n; the first
  // three clocks after reset release never count.
  function automatic void model_step();
    bit h_evt, v_evt, apply, rdq, hit;
    int data;
    n_edge++;
    h_evt = (n_edge >= 4) && hs2 && !hs3;
    v_evt = (n_edge >= 4) && vs2 && !vs3;
    apply = ce && !pause;
    rdq   = rd && ce;
    data  = v_pos * 16 + h_pos;
    hit   = 1'b0;
    model_axis(h_pos, h_acc, h_evt, hd2, apply, hit);
    model_axis(v_pos, v_acc, v_evt, vd2, apply, hit);
    if (hit) sat_m = 1'b1;
    else if (rdq) sat_m = 1'b0;
    if (rdq) exp_q.push_back({sat_m, data[7:0]});
    hs3 = hs2; hs2 = hs1; hs1 = h_clk; hd2 = hd1; hd1 = h_dir;
    vs3 = vs2; vs2 = vs1; vs1 = v_clk; vd2 = vd1; vd1 = v_dir;
  endfunction

  task automatic check(input string name, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // Drive inputs on the negedge, step the model on the posedge, then settle.
  task automatic tick(input logic ce_v, input logic pause_v, input logic rd_v);
    @(negedge clk);
    ce = ce_v; pause = pause_v; rd = rd_v;
    h_clk = nxt_h_clk; h_dir = nxt_h_dir; v_clk = nxt_v_clk; v_dir = nxt_v_dir;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle();
    if (ce_held) begin
      tick(1'b0, pause_g, 1'b0);
    end else begin
      ce_state = ~ce_state;
      tick(ce_state, pause_g, 1'b0);
    end
  endtask

  task automatic idle_n(input int n);
    for (int i = 0; i < n; i++) idle();
  endtask

  task automatic pulse(input bit vert, input bit up);
    if (vert) begin nxt_v_clk = 1'b1; nxt_v_dir = up; end
    else      begin nxt_h_clk = 1'b1; nxt_h_dir = up; end
    idle();
    if (vert) nxt_v_clk = 1'b0; else nxt_h_clk = 1'b0;
    idle();
  endtask

  task automatic do_read();
    tick(1'b1, 1'b0, 1'b1);
  endtask

  task automatic do_reset();
    tick(1'b0, pause_g, 1'b0);
    @(negedge clk);
    #2 reset_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_tb_data", int'(tb_data), 0);
    check("reset_sat", int'(sat), 0);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  // Monitor: a qualified read seen at a posedge is checked at the next negedge.
  logic rd_fire;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) rd_fire <= 1'b0;
    else          rd_fire <= rd & ce;
  end

  // Pop and compare the expected response for each read.
  always @(negedge clk) begin
    if (rd_fire) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL sb_empty: read seen with no expected value queued");
      end else begin
        logic [8:0] e;
        e = exp_q.pop_front();
        check("sb_tb_data", int'(tb_data), int'(e[7:0]));
        check("sb_sat", int'(sat), int'(e[8]));
      end
    end
  end

  initial begin
    reset_n = 1'b0;
    ce = 1'b0; pause = 1'b0; rd = 1'b0;
    h_clk = 1'b0; h_dir = 1'b0; v_clk = 1'b0; v_dir = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("por_tb_data", int'(tb_data), 0);
    check("por_sat", int'(sat), 0);
    @(negedge clk);
    reset_n = 1'b1;
    idle_n(4);

    // Five up-steps on h with ce toggling.
    for (int i = 0; i < 5; i++) pulse(1'b0, 1'b1);
    idle_n(8);
    do_read();
    check("five_up", int'(tb_data), 8'h05);
    check("five_up_sat", int'(sat), 0);

    // Wrap down from 0, then 17 up-steps wrap back to 0.
    do_reset();
    idle_n(4);
    pulse(1'b0, 1'b0);
    idle_n(8);
    do_read();
    check("wrap_down", int'(tb_data), 8'h0F);
    for (int i = 0; i < 17; i++) pulse(1'b0, 1'b1);
    idle_n(8);
    do_read();
    check("wrap_up", int'(tb_data), 8'h00);

    // Six v-steps while paused saturate the accumulator at +3.
    pause_g = 1'b1;
    for (int i = 0; i < 6; i++) pulse(1'b1, 1'b1);
    idle_n(4);
    pause_g = 1'b0;
    idle_n(6);
    check("sat_set", int'(sat), 1);
    do_read();
    check("sat_read_data", int'(tb_data), 8'h30);
    check("sat_cleared", int'(sat), 0);
    do_read();
    check("sat_read2", int'(sat), 0);

    // ce held low: +2 pending, third step lands on the clock ce returns.
    ce_held = 1'b1;
    pulse(1'b0, 1'b1);
    pulse(1'b0, 1'b1);
    nxt_h_clk = 1'b1; nxt_h_dir = 1'b1;
    tick(1'b0, 1'b0, 1'b0);
    nxt_h_clk = 1'b0;
    tick(1'b0, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b1);
    check("ce_return_plus2", int'(tb_data), 8'h32);
    idle();
    do_read();
    check("ce_return_total", int'(tb_data), 8'h33);

    // Read coinciding with an apply returns the pre-update count.
    pulse(1'b0, 1'b1);
    idle_n(3);
    do_read();
    check("rd_apply_pre", int'(tb_data), 8'h33);
    idle();
    do_read();
    check("rd_apply_post", int'(tb_data), 8'h34);

    // Reset with +3 pending and h_clk held high: nothing survives or counts.
    for (int i = 0; i < 3; i++) pulse(1'b0, 1'b1);
    nxt_h_clk = 1'b1;
    idle();
    do_reset();
    ce_held = 1'b0;
    idle_n(10);
    do_read();
    check("reset_hi_data", int'(tb_data), 8'h00);
    check("reset_hi_sat", int'(sat), 0);
    nxt_h_clk = 1'b0;
    idle_n(4);

    // Randomized traffic against the model.
    for (int i = 0; i < 800; i++) begin
      logic ce_r, pause_r, rd_r;
      ce_r    = 1'($urandom_range(0, 1));
      pause_r = ($urandom_range(0, 3) == 0);
      rd_r    = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 2) == 0) nxt_h_clk = ~nxt_h_clk;
      if ($urandom_range(0, 2) == 0) nxt_v_clk = ~nxt_v_clk;
      nxt_h_dir = 1'($urandom_range(0, 1));
      nxt_v_dir = 1'($urandom_range(0, 1));
      tick(ce_r, pause_r, rd_r);
    end
    nxt_h_clk = 1'b0; nxt_v_clk = 1'b0;
    pause_g = 1'b0;
    idle_n(8);
    do_read();
    idle_n(2);
    check("sb_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
